// File: rtl/segmented_pipeline_adder.sv
// Segmented carry-pipelined adder/subtractor: each stage adds one SEG_WIDTH slice
// and passes its carry, the finished low result and the pending upper operands on.
module segmented_pipeline_adder #(
    parameter int DATA_WIDTH = 16,
    parameter int SEG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  cout,
    output logic                  overflow
);

    localparam int NSEG = (SEG_WIDTH > 0) ? DATA_WIDTH / SEG_WIDTH : 1;
    localparam int TOP  = NSEG - 1;

    generate
        if ((SEG_WIDTH < 1) ? 1'b1 : ((DATA_WIDTH % SEG_WIDTH) != 0)) begin : g_bad_cfg
            $error("DATA_WIDTH must be a positive multiple of SEG_WIDTH");
        end
    endgenerate

    logic                  advance;
    logic [NSEG-1:0]       v_q;
    logic [NSEG-1:0]       v_d;
    logic [NSEG-1:0]       c_q;
    logic [NSEG-1:0]       c_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic [DATA_WIDTH-1:0] a_q [NSEG];
    logic [DATA_WIDTH-1:0] a_d [NSEG];
    logic [DATA_WIDTH-1:0] b_q [NSEG];
    logic [DATA_WIDTH-1:0] b_d [NSEG];
    logic [DATA_WIDTH-1:0] r_q [NSEG];
    logic [DATA_WIDTH-1:0] r_d [NSEG];

    logic [NSEG-1:0]       st_v;
    logic [NSEG-1:0]       st_c;
    logic [DATA_WIDTH-1:0] st_a [NSEG];
    logic [DATA_WIDTH-1:0] st_b [NSEG];
    logic [DATA_WIDTH-1:0] st_r [NSEG];
    logic [SEG_WIDTH:0]    seg_sum [NSEG];
    logic                  msb_cin;

    // A held result blocks the whole pipe; otherwise every stage shifts.
    assign in_ready  = !(out_valid && !out_ready);
    assign advance   = in_ready;
    assign out_valid = v_q[TOP];
    assign out       = r_q[TOP];
    assign cout      = c_q[TOP];
    assign overflow  = ovf_q;

    // Stage inputs: stage 0 takes the operands (subtract as in0 + ~in1 + 1), later stages their predecessor.
    always_comb begin
        st_v[0] = in_valid;
        st_a[0] = in0;
        st_b[0] = sub ? ~in1 : in1;
        st_c[0] = sub ? 1'b1 : cin;
        st_r[0] = '0;
        for (int k = 1; k < NSEG; k++) begin
            st_v[k] = v_q[k-1];
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = c_q[k-1];
            st_r[k] = r_q[k-1];
        end
    end

    // Per-stage segment add and next-state selection; invalid slots keep their old data.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            seg_sum[k] = {1'b0, st_a[k][k*SEG_WIDTH +: SEG_WIDTH]}
                       + {1'b0, st_b[k][k*SEG_WIDTH +: SEG_WIDTH]}
                       + {{SEG_WIDTH{1'b0}}, st_c[k]};
            v_d[k] = advance ? st_v[k] : v_q[k];
            if (advance && st_v[k]) begin
                a_d[k] = st_a[k];
                b_d[k] = st_b[k];
                r_d[k] = st_r[k];
                r_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg_sum[k][SEG_WIDTH-1:0];
                c_d[k] = seg_sum[k][SEG_WIDTH];
            end else begin
                a_d[k] = a_q[k];
                b_d[k] = b_q[k];
                r_d[k] = r_q[k];
                c_d[k] = c_q[k];
            end
        end
        // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c_in.
        msb_cin = st_a[TOP][DATA_WIDTH-1] ^ st_b[TOP][DATA_WIDTH-1] ^ seg_sum[TOP][SEG_WIDTH-1];
        if (advance && st_v[TOP]) begin
            ovf_d = msb_cin ^ seg_sum[TOP][SEG_WIDTH];
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
        end
    end

endmodule

// File: tb/tb_segmented_pipeline_adder.sv
// Self-checking bench for segmented_pipeline_adder (16-bit, 4-bit segments):
// table vectors, stall, bubble, random and mid-flight reset sequences against a scoreboard.
module tb_segmented_pipeline_adder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in0 = 16'h0000;
    logic [15:0] in1 = 16'h0000;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        cout;
    logic        overflow;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        s;
        logic [15:0] eo;
        logic        ec;
        logic        eov;
    } vec_t;

    typedef struct {
        logic [15:0] eo;
        logic        ec;
        logic        eov;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[12];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_o = 16'h0000;
    logic        exp_c = 1'b0;
    logic        exp_v = 1'b0;
    bit          exp_lat = 1'b0;
    logic [15:0] prev_out;
    logic        prev_c;
    logic        prev_ov;
    bit          prev_stall = 1'b0;

    segmented_pipeline_adder #(.DATA_WIDTH(16), .SEG_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: signed overflow from operand/result signs, carry from a 17-bit sum.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic c,
                                  input logic s, output logic [15:0] o, output logic co,
                                  output logic ov);
        logic [15:0] bb;
        logic [16:0] full;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'h0000, (s ? 1'b1 : c)};
        o    = full[15:0];
        co   = full[16];
        ov   = (a[15] == bb[15]) && (o[15] != a[15]);
    endfunction

    // Monitor on the falling edge: handshake rule, stall stability, scoreboard compare and push.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                check("stall_hold_out", {16'd0, out}, {16'd0, prev_out});
                check("stall_hold_cout", {31'd0, cout}, {31'd0, prev_c});
                check("stall_hold_ovf", {31'd0, overflow}, {31'd0, prev_ov});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h required=none (cycle %0d)", out, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result_out", {16'd0, out}, {16'd0, e.eo});
                    check("result_cout", {31'd0, cout}, {31'd0, e.ec});
                    check("result_ovf", {31'd0, overflow}, {31'd0, e.eov});
                    if (e.lat) check("latency", cyc - e.acc, LAT);
                end
            end
            if (in_valid && in_ready) sb.push_back('{exp_o, exp_c, exp_v, cyc + 1, exp_lat});
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            prev_c     = cout;
            prev_ov    = overflow;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] eo, input logic ec, input logic eov, input bit lat);
        logic ok;
        in0 = a; in1 = b; cin = c; sub = s;
        exp_o = eo; exp_c = ec; exp_v = eov; exp_lat = lat;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = in_ready && !reset;
            @(posedge clk);
            #1;
            if (ok) break;
            if (n == 199) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=not_accepted required=accepted");
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [15:0] a, input logic [15:0] b, input logic c,
                              input logic s, input bit lat);
        logic [15:0] o;
        logic        co;
        logic        ov;
        model(a, b, c, s, o, co, ov);
        send(a, b, c, s, o, co, ov, lat);
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[2]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[3]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'hCF13, 1'b0, 1'b0};
        tbl[6]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[8]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[9]  = '{16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
        tbl[10] = '{16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0};
        tbl[11] = '{16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0};

        // Reset state, observed while reset is still asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out", {16'd0, out}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Back-to-back table vectors; latency checked per result.
        for (int i = 0; i < 12; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].eo, tbl[i].ec, tbl[i].eov, 1'b1);
        drain();
        @(negedge clk);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_hold_out", {16'd0, out}, 32'h0008);

        // Bubbles between operations must not change latency.
        for (int i = 0; i < 4; i++) begin
            send_model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            repeat (i % 2 + 1) @(posedge clk);
            #1;
        end
        drain();

        // Full pipe, consumer stalls for three cycles.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_model(16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0);
        send_model(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        send_model(16'h9000, 16'h1000, 1'b0, 1'b1, 1'b0);
        send_model(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        fork
            send_model(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);
        join_none
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_first_out", {16'd0, out}, 32'h0011);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();

        // Random traffic with gaps and random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send_model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight; an operand offered during reset is refused.
        send_model(16'h0AAA, 16'h0001, 1'b0, 1'b0, 1'b0);
        send_model(16'h0BBB, 16'h0001, 1'b0, 1'b0, 1'b0);
        send_model(16'h0CCC, 16'h0001, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        sb.delete();
        in0 = 16'h5555; in1 = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        send_model(16'h2468, 16'h1357, 1'b0, 1'b0, 1'b1);
        drain();
        repeat (8) @(negedge clk);
        check("post_reset_quiet", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/segmented_pipeline_adder.md
SEGMENTED_PIPELINE_ADDER -- requirements
Module: segmented_pipeline_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter SEG_WIDTH, default 4, bits added per pipeline stage; NSEG = DATA_WIDTH/SEG_WIDTH.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in0  input  DATA_WIDTH  first operand.
REQ-008 in1  input  DATA_WIDTH  second operand.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = in0+in1+cin; 1 = in0-in1 (two's complement).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream consumes result this cycle.
REQ-013 out  output  DATA_WIDTH  sum/difference, modulo 2^DATA_WIDTH.
REQ-014 cout  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-015 overflow  output  1  signed overflow of the operation.

Function
REQ-016 Elaboration SHALL fail when DATA_WIDTH is not a multiple of SEG_WIDTH or SEG_WIDTH < 1.
REQ-017 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready at a rising edge.
REQ-018 Subtract SHALL be realised as in0 + ~in1 + 1; effective carry-in = sub ? 1 : cin.
REQ-019 Pipeline SHALL have NSEG stages; stage k adds segment k (bits k*SEG_WIDTH+SEG_WIDTH-1 .. k*SEG_WIDTH) using the carry registered by stage k-1 (stage 0 uses effective carry-in).
REQ-020 Each stage SHALL register its segment sum, carry, and the not-yet-added upper operand segments, plus a valid bit; lower result segments travel with the data.
REQ-021 Latency SHALL be NSEG cycles: an operand accepted at edge T yields out_valid=1 with its result after edge T+NSEG-1, absent stalls; NSEG=1 gives a single registered stage.
REQ-022 Throughput SHALL be one operation per cycle; results SHALL leave in acceptance order.
REQ-023 Stall: when out_valid=1 and out_ready=0 the whole pipeline SHALL hold; in_ready = !(out_valid && !out_ready).
REQ-024 While stalled, out, cout, overflow SHALL remain stable and no operand is lost or duplicated.
REQ-025 Bubbles (in_valid=0 while in_ready=1) SHALL propagate as invalid stages and not stall the pipe.
REQ-026 cout SHALL equal the carry out of the top segment; overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-027 out, cout, overflow SHALL be meaningful only when out_valid=1, but SHALL be held from their last valid values otherwise.
REQ-028 Simultaneous accept and emit in the same cycle SHALL both occur with no bubble inserted.

Reset
REQ-029 On reset=1 at a rising edge all stage valid bits, out_valid, out, cout, overflow SHALL clear to 0.
REQ-030 in_ready SHALL read 1 during and after reset (no output held valid).
REQ-031 Reset mid-operation SHALL discard every in-flight operation; no result for them ever appears.
REQ-032 in_valid during a reset cycle SHALL NOT be accepted.

Verification (DATA_WIDTH=16, SEG_WIDTH=4, NSEG=4)
REQ-033 Add 0xFFFF + 0x0001, cin=0, out_ready=1 -> after 4 edges out=0x0000, cout=1, overflow=0.
REQ-034 Sub 0x8000 - 0x0001 -> out=0x7FFF, cout=1, overflow=1; sub 0x0000 - 0x0001 -> out=0xFFFF, cout=0, overflow=0.
REQ-035 Carry ripple across all segments: 0x0FFF + 0x0000, cin=1 -> out=0x1000; 0x7FFF + 0x0001 -> 0x8000, overflow=1.
REQ-036 Four back-to-back ops (1+1, 2+2, 3+3, 4+4) -> outputs 0x0002, 0x0004, 0x0006, 0x0008 on consecutive cycles.
REQ-037 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, out stable for 3 cycles, all results delivered in order afterward.
REQ-038 Reset asserted 2 cycles after accepting 3 ops -> out_valid=0 next cycle; none of the 3 results appear; next accepted op emerges after 4 edges.
